// File: rtl/uart_receiver_fifo.sv
// Oversampled UART receiver: mid-bit sampling, false-start rejection, optional parity,
// per-frame error flags, and a first-word-fall-through FIFO with a valid/ready output side.
module uart_receiver_fifo #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 uart_samplig_clk,
   input  logic                 reset,
   input  logic                 RsRx,
   output logic                 valid,
   input  logic                 ready,
   output logic [DATA_BITS-1:0] received_data,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned CntW   = $clog2(OVERSAMPLE);
   localparam int unsigned BitW   = $clog2(DATA_BITS + 1);
   localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned EntryW = DATA_BITS + 2;

   localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

   logic                 rx_meta_q, rx_s_q;
   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 bit_end;
   logic                 push;
   logic [EntryW-1:0]    entry;

   logic [EntryW-1:0]    mem_q [FIFO_DEPTH];
   logic [AddrW:0]       wr_ptr_q, rd_ptr_q;
   logic                 empty, full, pop, wr_en;
   logic                 overrun_q;
   logic [EntryW-1:0]    head;

   always_ff @(posedge uart_samplig_clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= RsRx;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign bit_end = (cnt_q == CntLast);

   always_ff @(posedge uart_samplig_clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntW'(1);
      bit_d   = bit_q;
      data_d  = data_q;
      perr_d  = perr_q;
      unique case (state_q)
         StIdle: begin
            cnt_d  = '0;
            bit_d  = '0;
            perr_d = 1'b0;
            if (!rx_s_q) state_d = StStart;
         end
         StStart: begin
            // A start bit that is high again at mid-bit is treated as a glitch.
            if (cnt_q == CntHalf) begin
               cnt_d   = '0;
               state_d = rx_s_q ? StIdle : StData;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d  = '0;
               data_d = {rx_s_q, data_q[DATA_BITS-1:1]};
               if (bit_q == BitLast) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? StParity : StStop;
               end else begin
                  bit_d = bit_q + BitW'(1);
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               cnt_d   = '0;
               perr_d  = (PARITY == 2) ? ~(^data_q ^ rx_s_q) : (^data_q ^ rx_s_q);
               state_d = StStop;
            end
         end
         StStop: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = rx_s_q ? StIdle : StBreak;
            end
         end
         StBreak: begin
            cnt_d = '0;
            if (rx_s_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      push  = (state_q == StStop) && bit_end;
      entry = {~rx_s_q, perr_q, data_q};
   end

   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
              (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
      pop   = !empty && ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      wr_en = push && (!full || pop);
   end

   always_ff @(posedge uart_samplig_clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
         overrun_q <= push && full && !pop;
      end
   end

   always_ff @(posedge uart_samplig_clk) begin
      if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= entry;
   end

   assign head    = mem_q[rd_ptr_q[AddrW-1:0]];
   assign valid   = !empty;
   assign overrun = overrun_q;
   assign {frame_err, parity_err, received_data} = valid ? head : '0;

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Scoreboard bench for uart_receiver_fifo: three instances (no parity, even, odd),
// directed frames, and a negedge monitor that checks every handshake against the queue.
module tb_uart_receiver_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx    [3];
   logic       ready [3];
   logic       valid [3];
   logic [7:0] rdata [3];
   logic       perr  [3];
   logic       ferr  [3];
   logic       ovr   [3];

   always #5 clk = ~clk;

   uart_receiver_fifo u_dut0 (
      .uart_samplig_clk(clk), .reset(reset), .RsRx(rx[0]), .valid(valid[0]),
      .ready(ready[0]), .received_data(rdata[0]), .parity_err(perr[0]),
      .frame_err(ferr[0]), .overrun(ovr[0])
   );

   uart_receiver_fifo #(.PARITY(1)) u_dut1 (
      .uart_samplig_clk(clk), .reset(reset), .RsRx(rx[1]), .valid(valid[1]),
      .ready(ready[1]), .received_data(rdata[1]), .parity_err(perr[1]),
      .frame_err(ferr[1]), .overrun(ovr[1])
   );

   uart_receiver_fifo #(.PARITY(2)) u_dut2 (
      .uart_samplig_clk(clk), .reset(reset), .RsRx(rx[2]), .valid(valid[2]),
      .ready(ready[2]), .received_data(rdata[2]), .parity_err(perr[2]),
      .frame_err(ferr[2]), .overrun(ovr[2])
   );

   int          cyc       = 0;
   int          n_checks  = 0;
   int          n_pass    = 0;
   int          fall_cyc  = 0;
   int          rise_cyc  = 0;
   int          vhigh0    = 0;
   int          ovr_cnt0  = 0;
   int          pop_cnt0  = 0;
   logic        prev_v0   = 1'b0;
   logic        prev_hold0 = 1'b0;
   logic [9:0]  prev_out0 = '0;
   // Expected entry: {dut id[1:0], frame_err, parity_err, data[7:0]}
   logic [11:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one frame (16 clocks per bit); leaves the line at the stop-bit level.
   task automatic send_frame(input int id, input logic [7:0] d, input bit has_par,
                             input logic par, input logic stop);
      @(posedge clk);
      #1;
      rx[id]   = 1'b0;
      fall_cyc = cyc;
      repeat (16) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         #1 rx[id] = d[k];
         repeat (16) @(posedge clk);
      end
      if (has_par) begin
         #1 rx[id] = par;
         repeat (16) @(posedge clk);
      end
      #1 rx[id] = stop;
      repeat (16) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (valid[i] === 1'b1 && ready[i] === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_pop: dut %0d presented 0x%0h, expected nothing", i,
                        {ferr[i], perr[i], rdata[i]});
            end else begin
               logic [11:0] e;
               logic [1:0]  id;
               e  = exp_q.pop_front();
               id = i[1:0];
               check("pop_entry", {id, ferr[i], perr[i], rdata[i]}, e);
            end
         end
      end
      if (valid[0] && !prev_v0) rise_cyc = cyc;
      prev_v0 = valid[0];
      if (valid[0]) vhigh0++;
      if (ovr[0]) ovr_cnt0++;
      if (valid[0] && ready[0]) pop_cnt0++;
      if (prev_hold0 && valid[0]) check("hold_stable", {ferr[0], perr[0], rdata[0]}, prev_out0);
      prev_hold0 = valid[0] && !ready[0];
      prev_out0  = {ferr[0], perr[0], rdata[0]};
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx[i]    = 1'b1;
         ready[i] = 1'b1;
      end
      wait_cyc(3);
      check("rst_valid", valid[0], 0);
      check("rst_data", rdata[0], 0);
      check("rst_perr", perr[0], 0);
      check("rst_ferr", ferr[0], 0);
      check("rst_overrun", ovr[0], 0);
      reset = 1'b0;
      wait_cyc(5);

      // 0xA5, 8N1: valid must rise 155 clocks after the pin falls and last one cycle.
      vhigh0   = 0;
      rise_cyc = 0;
      exp_q.push_back({2'd0, 2'b00, 8'hA5});
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      wait_cyc(4);
      check("a5_latency", rise_cyc - fall_cyc, 155);
      check("a5_valid_cycles", vhigh0, 1);

      // Short low glitch must be rejected, then a normal frame follows.
      rx[0] = 1'b0;
      wait_cyc(3);
      rx[0] = 1'b1;
      wait_cyc(10);
      check("glitch_no_valid", valid[0], 0);
      exp_q.push_back({2'd0, 2'b00, 8'h3C});
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_cyc(5);

      // 0x07 has odd weight: even parity expects 1, odd parity expects 0.
      exp_q.push_back({2'd1, 2'b00, 8'h07});
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      exp_q.push_back({2'd1, 2'b01, 8'h07});
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
      exp_q.push_back({2'd2, 2'b01, 8'h07});
      send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
      exp_q.push_back({2'd2, 2'b00, 8'h07});
      send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1);
      wait_cyc(5);

      // Low stop bit followed by a 3-bit-time break: exactly one flagged entry.
      exp_q.push_back({2'd0, 2'b10, 8'h55});
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
      wait_cyc(48);
      rx[0] = 1'b1;
      wait_cyc(16);
      exp_q.push_back({2'd0, 2'b00, 8'h12});
      send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
      wait_cyc(5);

      // Fill with ready low; the fifth frame overflows.
      ready[0] = 1'b0;
      ovr_cnt0 = 0;
      pop_cnt0 = 0;
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back({2'd0, 2'b00, k[7:0]});
         send_frame(0, k[7:0], 1'b0, 1'b0, 1'b1);
      end
      check("ovr_after4", ovr_cnt0, 0);
      check("full_valid", valid[0], 1);
      send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1);
      check("ovr_after5", ovr_cnt0, 1);
      check("full_head", rdata[0], 8'h01);
      ready[0] = 1'b1;
      wait_cyc(8);
      check("drain_pops", pop_cnt0, 4);
      check("drain_valid", valid[0], 0);

      // Reset mid-frame with an entry held in the FIFO.
      ready[0] = 1'b0;
      send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
      check("pre_reset_valid", valid[0], 1);
      check("pre_reset_data", rdata[0], 8'h81);
      fork
         send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
         begin
            wait_cyc(96);
            reset = 1'b1;
            wait_cyc(1);
            check("mid_rst_valid", valid[0], 0);
            check("mid_rst_data", rdata[0], 0);
            check("mid_rst_perr", perr[0], 0);
            check("mid_rst_ferr", ferr[0], 0);
            check("mid_rst_overrun", ovr[0], 0);
            reset = 1'b0;
         end
      join
      ready[0] = 1'b1;
      wait_cyc(5);
      check("post_rst_empty", valid[0], 0);
      exp_q.push_back({2'd0, 2'b00, 8'hC3});
      send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
